// File: rtl/mul_seq_ctrl.sv
// Multi-cycle radix-2 shift-add MUL sequencer beside the EX ALU; stalls the pipeline until the low XLEN product bits are ready.
// Optional MUL_SEQ_EARLY_EXIT_EN: leave BUSY as soon as the remaining multiplier bits are all zero.
`ifndef MUL_FUNCT3
`define MUL_FUNCT3 3'b110
`endif
`ifndef ADD_FUNCT3
`define ADD_FUNCT3 3'b000
`endif

module mul_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            mul_busy,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] acc_q, a_sh_q, b_sh_q, mul_result_q;
  logic            mul_busy_q, mul_done_q;
  logic            start, last_step;
  logic [XLEN-1:0] acc_step;

  assign start = ex_valid & (alu_control == `MUL_FUNCT3) & ~flush;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // No multiplier bits left after this step means no further adds can change acc.
  assign last_step = (count_q == CW'(XLEN - 1)) || ((b_sh_q >> 1) == '0);
`else
  assign last_step = (count_q == CW'(XLEN - 1));
`endif

  assign acc_step = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = BUSY;
      end
      BUSY: begin
        if (flush)          state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = start;
      BUSY:    stall = ~flush;
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      acc_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      mul_result_q <= '0;
      mul_busy_q   <= 1'b0;
      mul_done_q   <= 1'b0;
    end else begin
      mul_busy_q <= (state_d == BUSY);
      mul_done_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= src_a;
            b_sh_q  <= src_b;
            acc_q   <= '0;
            count_q <= '0;
          end
        end
        BUSY: begin
          if (!flush) begin
            acc_q   <= acc_step;
            a_sh_q  <= a_sh_q << 1;
            b_sh_q  <= b_sh_q >> 1;
            count_q <= count_q + 1'b1;
            if (last_step) mul_result_q <= acc_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_busy   = mul_busy_q;
  assign mul_done   = mul_done_q;
  assign mul_result = mul_result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: table of MUL vectors plus flush, reset, back-to-back and non-MUL sequences.
`ifndef MUL_FUNCT3
`define MUL_FUNCT3 3'b110
`endif
`ifndef ADD_FUNCT3
`define ADD_FUNCT3 3'b000
`endif

module tb_mul_seq_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] src_a, src_b;
  logic            flush;
  logic            stall, mul_busy, mul_done;
  logic [XLEN-1:0] mul_result;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[6];

  mul_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .mul_busy    (mul_busy),
    .mul_done    (mul_done),
    .mul_result  (mul_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stall cycles including the request cycle.
  function automatic int exp_stall(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return 1 + ((msb + 1) < 1 ? 1 : (msb + 1));
`else
    return XLEN + 1;
`endif
  endfunction

  // Called just after a rising edge; holds the MUL in EX until mul_done is seen.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input string nm);
    int  st_cnt = 0;
    int  cyc = 0;
    bit  seen = 0;
    ex_valid    = 1'b1;
    alu_control = `MUL_FUNCT3;
    src_a       = a;
    src_b       = b;
    flush       = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (mul_done) begin
        seen = 1;
        check({nm, "_done_stall"}, stall, 0);
        check({nm, "_result"}, mul_result, exp_r);
      end else if (stall) begin
        st_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_done_seen"}, seen, 1);
    check({nm, "_stall_cycles"}, st_cnt, exp_stall(b));
  endtask

  task automatic idle_after(input string nm);
    ex_valid = 1'b0;
    @(negedge clk);
    check({nm, "_single_pulse"}, mul_done, 0);
    check({nm, "_idle_stall"}, stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] prev;
    int bad;
    int dones;

    vecs[0] = '{32'd7,        32'd6,        32'd42};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[3] = '{32'd5,        32'd0,        32'd0};
    vecs[4] = '{32'h00010000, 32'h00010000, 32'd0};
    vecs[5] = '{32'd1,        32'h80000000, 32'h80000000};

    rst_n = 1'b0; ex_valid = 1'b0; alu_control = '0;
    src_a = '0; src_b = '0; flush = 1'b0;
    #12;
    check("reset_stall", stall, 0);
    check("reset_busy", mul_busy, 0);
    check("reset_done", mul_done, 0);
    check("reset_result", mul_result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].exp_r, $sformatf("vec%0d", i));
      idle_after($sformatf("vec%0d", i));
    end

    // Non-MUL ops never stall.
    ex_valid = 1'b1; alu_control = `ADD_FUNCT3; src_a = 32'd9; src_b = 32'd9;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stall || mul_busy || mul_done) bad++;
      @(posedge clk); #1;
    end
    check("add_no_stall", bad, 0);
    ex_valid = 1'b0;
    @(posedge clk); #1;

    // Flush in BUSY cycle 10.
    prev = mul_result;
    ex_valid = 1'b1; alu_control = `MUL_FUNCT3; src_a = 32'd100; src_b = 32'd100;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_low", stall, 0);
    check("flush_busy_still", mul_busy, 1);
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", mul_busy, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_done) dones++;
    end
    check("flush_no_done", dones, 0);
    check("flush_result_kept", mul_result, prev);
    @(posedge clk); #1;
    run_mul(32'd3, 32'd4, 32'd12, "after_flush");
    idle_after("after_flush");

    // Back-to-back: second request presented the cycle after DONE.
    run_mul(32'd2, 32'd3, 32'd6, "b2b_first");
    run_mul(32'd4, 32'd5, 32'd20, "b2b_second");
    idle_after("b2b");

    // Asynchronous reset mid-BUSY.
    ex_valid = 1'b1; alu_control = `MUL_FUNCT3; src_a = 32'd50; src_b = 32'd50;
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_busy", mul_busy, 1);
    rst_n = 1'b0; ex_valid = 1'b0;
    #1;
    check("async_rst_stall", stall, 0);
    check("async_rst_busy", mul_busy, 0);
    check("async_rst_done", mul_done, 0);
    check("async_rst_result", mul_result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_mul(32'd9, 32'd9, 32'd81, "after_reset");
    idle_after("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the MUL operation selected by the ALU decoder (ALUControl == `MUL_FUNCT3 from constants.v).
- Sits beside the EX-stage ALU. Detects a valid MUL in EX and stalls the pipeline while it computes the low XLEN bits of src_a*src_b with a radix-2 shift-add loop.
- Returns a one-cycle-valid result to the EX result mux. All non-MUL ops pass through without stall.

Parameters:
- XLEN, 32, operand and result width; must be a power of two, >= 8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- alu_control  in  3  ALUControl from ALU decoder
- src_a  in  XLEN  multiplicand
- src_b  in  XLEN  multiplier
- flush  in  1  EX-stage flush (branch/exception)
- stall  out  1  freeze IF/ID/EX; combinational from state and inputs
- mul_busy  out  1  registered; high in BUSY
- mul_done  out  1  registered; one-cycle pulse, mul_result valid
- mul_result  out  XLEN  low XLEN bits of product

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count, acc, a_sh, b_sh = 0.
  - stall=0, mul_busy=0, mul_done=0, mul_result=0.
- start = ex_valid & (alu_control == `MUL_FUNCT3) & ~flush.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = start.
  - On start: a_sh<=src_a, b_sh<=src_b, acc<=0, count<=0, go BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stall=1.
  - Each cycle: if b_sh[0], acc<=acc+a_sh (mod 2^XLEN); a_sh<=a_sh<<1; b_sh<=b_sh>>1; count<=count+1.
  - When count==XLEN-1: mul_result<=final acc including this step's add, mul_done<=1, go DONE.
- DONE:
  - stall=0, mul_done=1; pipeline advances at the end of this cycle.
  - Go IDLE unconditionally. Requests are not sampled in DONE, so the same MUL cannot retrigger.
  - mul_result holds its value until the next DONE.
- Latency: request cycle + XLEN BUSY cycles. stall is high for XLEN+1 cycles; mul_done is asserted in cycle XLEN+1 (request cycle = 0).
- Signedness: low-half product is identical for signed and unsigned operands; no sign handling.
- count width: $clog2(XLEN)+1. Wraps only via reload on start.
- flush priority:
  - flush in BUSY: go IDLE, stall=0 that same cycle, no mul_done, mul_result unchanged.
  - flush in DONE: ignored; the result is already delivered.
  - flush with a MUL request in IDLE: no start.
- ex_valid or alu_control changing during BUSY: ignored; operands are latched.
- Back-to-back MULs: the second is started from IDLE the cycle after DONE. Stall gap = 1 cycle (DONE).
- Reset mid-operation: immediate return to reset values; no mul_done.

Optional Feature:
- Macro: MUL_SEQ_EARLY_EXIT_EN.
- Defined:
  - In BUSY, leave for DONE at the end of the first cycle where (b_sh>>1)==0, or when count==XLEN-1, whichever comes first.
  - Minimum one BUSY cycle, even when src_b==0.
  - Latency = 1 + max(1, index of highest set bit of src_b + 1) cycles of stall.
- Undefined: fixed XLEN BUSY cycles; no zero detect logic.
- Results must be identical in both builds.

Test Plan:
- XLEN=32, src_a=7, src_b=6, MUL with ex_valid=1 -> stall high 33 cycles; mul_done pulse in cycle 33 with mul_result=42; stall low in that cycle.
- src_a=0xFFFFFFFD (-3), src_b=5 -> mul_result=0xFFFFFFF1. Then src_a=src_b=0xFFFFFFFF -> mul_result=0x00000001.
- ex_valid=1 with alu_control=`ADD_FUNCT3 for 10 cycles -> stall, mul_busy, mul_done stay 0.
- MUL started; flush=1 in BUSY cycle 10 ->
  - stall=0 that cycle, IDLE next, no mul_done.
  - A following MUL 3*4 yields 12 after 33 cycles.
- Two MULs back-to-back (2*3, 4*5) ->
  - results 6 then 20.
  - Exactly one non-stall cycle (DONE) between the stall windows.
  - Each MUL produces exactly one mul_done.
- rst_n=0 asynchronously mid-BUSY -> all outputs 0 immediately. After release, 9*9 yields 81.
- With MUL_SEQ_EARLY_EXIT_EN defined: 7*6 -> stall 4 cycles (1+3 BUSY), result 42. 5*0 -> stall 2 cycles, result 0.
